// File: rtl/instr_fetch_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, the canonical NOP
// and major opcodes used by fetch, decode and ImmGen.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode
// hand-off and execute redirect, seen from the fetch unit (master) and its peers.
interface instr_fetch_if;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic [31:0] instruction;
  logic [31:0] pcOut;
  logic        instrValid;
  logic        instrReady;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        misaligned;

  modport master (
    output imemReq, imemAddr, instruction, pcOut, instrValid, misaligned,
    input  imemValid, imemRdata, instrReady, branchTaken, branchTarget
  );

  modport slave (
    input  imemReq, imemAddr, instruction, pcOut, instrValid, misaligned,
    output imemValid, imemRdata, instrReady, branchTaken, branchTarget
  );

endinterface

// File: rtl/instr_fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC while the output
// register is blocked by decode back-pressure.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [31:0] r_pc;

  // Flush beats push/pop so a redirect never leaves a stale entry behind
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and hands instruction+PC to decode with a skid buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instr_fetch_pkg::NOP_INSTR
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);
  import instr_fetch_pkg::*;

  fetch_state_t r_state, w_nextState;

  logic [31:0] r_pc;
  logic [31:0] r_dropAddr;
  logic [31:0] r_instr;
  logic [31:0] r_pcOut;
  logic        r_instrValid;
  logic        r_misaligned;

  logic        w_transfer;
  logic        w_loadOut;
  logic        w_fromSkid;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_skidValid;
  logic [31:0] w_skidData;
  logic [31:0] w_skidPc;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_target;

  assign w_transfer = r_instrValid & bus.instrReady;
  assign w_pcPlus4  = r_pc + 32'd4;
  assign w_target   = {bus.branchTarget[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_nextState;
  end

  // A redirect overrides every other decision; otherwise a returned word goes
  // to the output register when it is free or draining, else to the skid.
  always_comb begin
    w_nextState = r_state;
    w_loadOut   = 1'b0;
    w_fromSkid  = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    if (bus.branchTaken) begin
      w_flush = 1'b1;
      case (r_state)
        S_FETCH, S_DROP: w_nextState = bus.imemValid ? S_FETCH : S_DROP;
        default:         w_nextState = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_RESET: w_nextState = S_FETCH;
        S_FETCH: begin
          if (bus.imemValid) begin
            if (!r_instrValid || w_transfer) begin
              w_loadOut = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_nextState = S_STALL;
            end
          end
        end
        S_STALL: begin
          if (w_transfer) begin
            w_fromSkid  = 1'b1;
            w_pop       = 1'b1;
            w_nextState = S_FETCH;
          end
        end
        S_DROP:  if (bus.imemValid) w_nextState = S_FETCH;
        default: w_nextState = S_RESET;
      endcase
    end
  end

  // The stale address is held in S_DROP so the outstanding request stays stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_dropAddr   <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pcOut      <= RESET_PC;
      r_instrValid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= bus.branchTaken & (|bus.branchTarget[1:0]);
      if (bus.branchTaken) begin
        r_instrValid <= 1'b0;
        r_instr      <= NOP_INSTR;
        r_pc         <= w_target;
        if (r_state == S_FETCH) r_dropAddr <= r_pc;
      end else begin
        if (w_loadOut) begin
          r_instr      <= bus.imemRdata;
          r_pcOut      <= r_pc;
          r_instrValid <= 1'b1;
        end else if (w_fromSkid) begin
          r_instr      <= w_skidData;
          r_pcOut      <= w_skidPc;
          r_instrValid <= 1'b1;
        end else if (w_transfer) begin
          r_instrValid <= 1'b0;
        end
        if (r_state == S_FETCH && bus.imemValid) r_pc <= w_pcPlus4;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .i_data (bus.imemRdata),
    .i_pc   (r_pc),
    .o_valid(w_skidValid),
    .o_data (w_skidData),
    .o_pc   (w_skidPc)
  );

  assign bus.imemReq     = (r_state == S_FETCH) || (r_state == S_DROP);
  assign bus.imemAddr    = (r_state == S_DROP) ? r_dropAddr : r_pc;
  assign bus.instruction = r_instr;
  assign bus.pcOut       = r_pcOut;
  assign bus.instrValid  = r_instrValid;
  assign bus.misaligned  = r_misaligned;

endmodule
